// File: rtl/ufp_line_responder_if.sv
// Bundle of the ufp word-request port and the dfp line port seen by ufp_line_responder.
// master = requester/memory side (drives requests and refills), slave = the responder.
interface ufp_line_responder_if;
    logic [31:0]  ufp_addr;
    logic [3:0]   ufp_rmask;
    logic [3:0]   ufp_wmask;
    logic [31:0]  ufp_wdata;
    logic [31:0]  ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    modport master (
        output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        input  ufp_rdata, ufp_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );

    modport slave (
        input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        output ufp_rdata, ufp_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/ufp_line_responder.sv
// Single-line word responder: serves ufp requests from one 256-bit line, write-back/refill over dfp.
// Define UFP_RESP_PERF_EN to add the perf_hits/perf_misses acceptance counters.
module ufp_line_responder #(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef UFP_RESP_PERF_EN
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
`endif
    ufp_line_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t                       state, state_next;
    logic [LINE_WORDS-1:0][31:0]  line;
    logic [26:0]                  tag;
    logic                         valid, dirty;

    logic [26:0] req_tag;
    logic [2:0]  req_offset;
    logic [3:0]  req_rmask, req_wmask;
    logic [31:0] req_wdata;

    logic        req_valid, hit, accept, req_is_write, dirty_eff;
    logic [31:0] merged_word;
    logic        unused_addr_bits;

    assign req_valid        = |{bus.ufp_rmask, bus.ufp_wmask};
    assign hit              = valid && (tag == bus.ufp_addr[31:5]);
    assign accept           = (state == IDLE || state == RESP) && req_valid;
    assign req_is_write     = |req_wmask;
    // A write finishing this cycle dirties the line at the same edge a miss is decided.
    assign dirty_eff        = dirty || (state == RESP && req_is_write);
    assign unused_addr_bits = ^bus.ufp_addr[1:0];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next    = state;
        bus.ufp_resp  = 1'b0;
        bus.ufp_rdata = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        bus.dfp_addr  = '0;
        bus.dfp_wdata = '0;
        unique case (state)
            IDLE, RESP: begin
                if (state == RESP) begin
                    bus.ufp_resp = 1'b1;
                    if (!req_is_write && (|req_rmask)) bus.ufp_rdata = line[req_offset];
                end
                if (!req_valid)    state_next = IDLE;
                else if (hit)      state_next = RESP;
                else if (dirty_eff) state_next = WB;
                else               state_next = FILL;
            end
            WB: begin
                bus.dfp_write = 1'b1;
                bus.dfp_addr  = {tag, 5'b0};
                bus.dfp_wdata = line;
                if (bus.dfp_resp) state_next = FILL;
            end
            FILL: begin
                bus.dfp_read = 1'b1;
                bus.dfp_addr = {req_tag, 5'b0};
                if (bus.dfp_resp) state_next = RESP;
            end
        endcase
    end

    always_comb begin
        merged_word = line[req_offset];
        for (int b = 0; b < 4; b++) begin
            if (req_wmask[b]) merged_word[b*8 +: 8] = req_wdata[b*8 +: 8];
        end
    end

    // NOTE: line data, tag and the latched request are not reset; valid and state gate their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_tag    <= bus.ufp_addr[31:5];
            req_offset <= bus.ufp_addr[4:2];
            req_rmask  <= bus.ufp_rmask;
            req_wmask  <= bus.ufp_wmask;
            req_wdata  <= bus.ufp_wdata;
        end
        if (state == FILL && bus.dfp_resp) begin
            line <= bus.dfp_rdata;
            tag  <= req_tag;
        end else if (state == RESP && req_is_write) begin
            line[req_offset] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dirty <= 1'b0;
        end else begin
            unique case (state)
                WB:   if (bus.dfp_resp) dirty <= 1'b0;
                FILL: if (bus.dfp_resp) begin
                          valid <= 1'b1;
                          dirty <= 1'b0;
                      end
                RESP: if (req_is_write) dirty <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UFP_RESP_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (accept) begin
            if (hit) perf_hits   <= perf_hits + 32'd1;
            else     perf_misses <= perf_misses + 32'd1;
        end
    end
`else
    // Counters are absent in this build; behaviour is otherwise identical.
`endif
endmodule

// File: tb/tb_ufp_line_responder.sv
// Directed bench for ufp_line_responder: table of back-to-back hits plus miss/writeback/reset sequences.
module tb_ufp_line_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ufp_line_responder_if bus();
`ifdef UFP_RESP_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    ufp_line_responder dut (
        .clk(clk),
        .rst(rst),
`ifdef UFP_RESP_PERF_EN
        .perf_hits(perf_hits),
        .perf_misses(perf_misses),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t         vecs[9];
    int           checks = 0;
    int           errors = 0;
    int           resp_seen = 0;
    logic [255:0] line_a, line_b, exp_wb;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.ufp_resp) resp_seen++;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic [3:0] rmask,
                           input logic [3:0] wmask, input logic [31:0] wdata);
        bus.ufp_addr  = addr;
        bus.ufp_rmask = rmask;
        bus.ufp_wmask = wmask;
        bus.ufp_wdata = wdata;
    endtask

    task automatic idle_req();
        set_req(32'h0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'hA0A0_0000 + i;
            line_b[i*32 +: 32] = 32'hB0B0_0000 + i;
        end
        line_a[1*32 +: 32] = 32'hDEAD_BEEF;
        line_a[2*32 +: 32] = 32'h1122_3344;

        // Back-to-back hits on the resident 0x1000 line (line_a), each expecting ufp_resp in N+1.
        vecs[0] = '{32'h1008, 4'h0, 4'b0011, 32'h0000_ABCD, 32'h0};
        vecs[1] = '{32'h1008, 4'hF, 4'h0,    32'h0,         32'h1122_ABCD};
        vecs[2] = '{32'h1004, 4'hF, 4'h0,    32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{32'h101C, 4'h0, 4'b1100, 32'hCAFE_0000, 32'h0};
        vecs[4] = '{32'h1000, 4'hF, 4'b1000, 32'h5500_0000, 32'h0};
        vecs[5] = '{32'h101C, 4'hF, 4'h0,    32'h0,         32'hCAFE_0007};
        vecs[6] = '{32'h1000, 4'b0001, 4'h0, 32'h0,         32'h55A0_0000};
        vecs[7] = '{32'h1004, 4'h0, 4'b0100, 32'h0077_0000, 32'h0};
        vecs[8] = '{32'h1004, 4'hF, 4'h0,    32'h0,         32'hDE77_BEEF};

        exp_wb = line_a;
        exp_wb[0*32 +: 32] = 32'h55A0_0000;
        exp_wb[1*32 +: 32] = 32'hDE77_BEEF;
        exp_wb[2*32 +: 32] = 32'h1122_ABCD;
        exp_wb[7*32 +: 32] = 32'hCAFE_0007;

        // Reset
        rst = 1'b1;
        idle_req();
        bus.dfp_resp  = 1'b0;
        bus.dfp_rdata = '0;
        tick();
        tick();
        check("rst_ufp_resp",  bus.ufp_resp,  0);
        check("rst_ufp_rdata", bus.ufp_rdata, 0);
        check("rst_dfp_read",  bus.dfp_read,  0);
        check("rst_dfp_write", bus.dfp_write, 0);
        check("rst_dfp_addr",  bus.dfp_addr,  0);
        check("rst_dfp_wdata", bus.dfp_wdata, 0);
        rst = 1'b0;
        resp_seen = 0;

        // Clean miss on 0x1004, request held through FILL
        set_req(32'h1004, 4'hF, 4'h0, 32'h0);
        tick();
        check("miss_dfp_read",  bus.dfp_read,  1);
        check("miss_dfp_write", bus.dfp_write, 0);
        check("miss_dfp_addr",  bus.dfp_addr,  32'h1000);
        check("miss_no_resp",   bus.ufp_resp,  0);
        tick();
        check("miss_read_held", bus.dfp_read, 1);
        bus.dfp_rdata = line_a;
        bus.dfp_resp  = 1'b1;
        tick();
        bus.dfp_resp = 1'b0;
        idle_req();
        check("miss_resp",       bus.ufp_resp,  1);
        check("miss_rdata",      bus.ufp_rdata, 32'hDEAD_BEEF);
        check("miss_read_drop",  bus.dfp_read,  0);
        tick();
        check("idle_resp_low",   bus.ufp_resp,  0);
        check("idle_rdata_zero", bus.ufp_rdata, 0);
        check("miss_resp_count", resp_seen, 1);

        // Table of back-to-back hits
        resp_seen = 0;
        for (int i = 0; i < 9; i++) begin
            set_req(vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata);
            tick();
            check($sformatf("vec%0d_resp", i),  bus.ufp_resp,  1);
            check($sformatf("vec%0d_rdata", i), bus.ufp_rdata, vecs[i].rdata);
            check($sformatf("vec%0d_no_dfp", i), {bus.dfp_read, bus.dfp_write}, 0);
        end
        idle_req();
        tick();
        check("hits_end_idle",   bus.ufp_resp, 0);
        check("hits_resp_count", resp_seen, 9);

        // Dirty miss to 0x2000: writeback of merged line, then refill; request dropped after acceptance
        resp_seen = 0;
        set_req(32'h2000, 4'hF, 4'h0, 32'h0);
        tick();
        idle_req();
        check("wb_dfp_write", bus.dfp_write, 1);
        check("wb_dfp_read",  bus.dfp_read,  0);
        check("wb_dfp_addr",  bus.dfp_addr,  32'h1000);
        check("wb_dfp_wdata", bus.dfp_wdata, exp_wb);
        tick();
        check("wb_write_held", bus.dfp_write, 1);
        bus.dfp_resp = 1'b1;
        tick();
        bus.dfp_resp = 1'b0;
        check("fill_write_drop", bus.dfp_write, 0);
        check("fill_dfp_read",   bus.dfp_read,  1);
        check("fill_dfp_addr",   bus.dfp_addr,  32'h2000);
        // A new request during FILL is ignored until RESP
        set_req(32'h1004, 4'hF, 4'h0, 32'h0);
        tick();
        check("fill_ignores_req", bus.dfp_addr, 32'h2000);
        check("fill_no_resp",     bus.ufp_resp, 0);
        bus.dfp_rdata = line_b;
        bus.dfp_resp  = 1'b1;
        tick();
        bus.dfp_resp = 1'b0;
        check("wbmiss_resp",  bus.ufp_resp,  1);
        check("wbmiss_rdata", bus.ufp_rdata, 32'hB0B0_0000);
        // Request still presented in RESP is sampled: clean miss to 0x1000
        tick();
        idle_req();
        check("resp_sample_read", bus.dfp_read, 1);
        check("resp_sample_addr", bus.dfp_addr, 32'h1000);
        check("resp_sample_resp", bus.ufp_resp, 0);
        check("wbmiss_resp_count", resp_seen, 1);

        // Reset while in FILL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstfill_dfp_read",  bus.dfp_read,  0);
        check("rstfill_dfp_write", bus.dfp_write, 0);
        check("rstfill_no_resp",   bus.ufp_resp,  0);
        tick();
        check("rstfill_resp_count", resp_seen, 1);

        // Line invalidated by reset: 0x2000 misses again, then two hits
        set_req(32'h2000, 4'hF, 4'h0, 32'h0);
        tick();
        check("remiss_dfp_read", bus.dfp_read, 1);
        check("remiss_dfp_addr", bus.dfp_addr, 32'h2000);
        bus.dfp_rdata = line_b;
        bus.dfp_resp  = 1'b1;
        tick();
        bus.dfp_resp = 1'b0;
        set_req(32'h2004, 4'hF, 4'h0, 32'h0);
        check("remiss_rdata", bus.ufp_rdata, 32'hB0B0_0000);
        tick();
        set_req(32'h2008, 4'hF, 4'h0, 32'h0);
        check("hit1_rdata",  bus.ufp_rdata, 32'hB0B0_0001);
        check("hit1_no_dfp", bus.dfp_read,  0);
        tick();
        idle_req();
        check("hit2_rdata", bus.ufp_rdata, 32'hB0B0_0002);
        tick();
        check("final_idle", bus.ufp_resp, 0);
`ifdef UFP_RESP_PERF_EN
        check("perf_misses", perf_misses, 1);
        check("perf_hits",   perf_hits,   2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
